circuit_2_sweep_checker: RTL
============================

Name: circuit_2_sweep_checker

Overview:
- Self-checking harness stage wrapped around the combinational 3-input block circuit_2 (inputs a, b, c; output o).
- Upstream role: drives all 8 input combinations {a,b,c} = 0..7 in ascending order.
- Downstream role: after a fixed settle window, samples the block's output o and compares it with a truth-table constant.
- Reports per-vector failures, an error count, and a pass/done summary.
- Used in gate-level delay regression, where the worst-case path is or(8) -> and(6) -> xor(4) -> and(2) = 20 time units.

Parameters:
- SETTLE_CYCLES, 24: clock cycles each vector is held before sampling. Minimum 1. Must cover the 20-unit worst-case path at the chosen clock period.
- EXPECTED, 8'hE2: expected o per vector; bit index = {a,b,c}. Derived: 0->0, 1->1, 2->0, 3->0, 4->0, 5->1, 6->1, 7->1.
- CNT_W, 8: settle counter width. Must satisfy 2^CNT_W > SETTLE_CYCLES.

Ports:
- clk  input  1  the single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
- o_in  input  1  output o of the block under check.
- a  output  1  vector bit 2 driven to block input a.
- b  output  1  vector bit 1 driven to block input b.
- c  output  1  vector bit 0 driven to block input c.
- busy  output  1  high while a sweep is in progress.
- done  output  1  sticky; high from sweep completion until the next accepted start or reset.
- pass  output  1  valid when done=1; high iff err_count==0.
- err_count  output  4  number of mismatching vectors, range 0..8.
- fail_mask  output  8  bit i set if vector i mismatched.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, vec=0, settle counter=0. All outputs 0: a, b, c, busy, done, pass, err_count, fail_mask.
- Reset mid-sweep aborts immediately with the same values; no partial results are kept.
- a, b, c are registered outputs and always equal vec[2:0]. No combinational path from any input to any output.

FSM states and transitions:
- IDLE: on start=1, load vec<=0, cnt<=0, err_count<=0, fail_mask<=0, done<=0, pass<=0, busy<=1; go to SETTLE. With start=0, hold all outputs.
- SETTLE: cnt increments each cycle. When cnt==SETTLE_CYCLES-1, go to SAMPLE.
- SAMPLE: compare o_in with EXPECTED[vec].
  - On mismatch: fail_mask[vec]<=1 and err_count<=err_count+1.
  - If vec==7: busy<=0, done<=1, pass<=(no mismatch this sweep including this sample); go to IDLE.
  - Otherwise: vec<=vec+1, cnt<=0; go to SETTLE.

Timing:
- Each vector is driven for exactly SETTLE_CYCLES+1 cycles. o_in is sampled in the last of those cycles.
- Total busy = 8*(SETTLE_CYCLES+1) cycles. Default: 200 cycles.
- done and busy change in the cycle after the final SAMPLE edge.

Boundary conditions:
- start while busy: ignored, with no effect on the counter or vec.
- start in the same cycle that done rises (SAMPLE->IDLE edge): ignored, because the FSM was not in IDLE.
- start in IDLE while done=1: clears results and restarts the sweep.
- start and rst both high: rst wins.
- SETTLE_CYCLES=1: each vector lasts 2 cycles (SETTLE then SAMPLE).
- vec does not wrap; the sweep ends after vector 7.
- err_count saturation is not needed, since the maximum is 8 and fits in 4 bits.
- o_in is X or Z at sample time: counts as a mismatch. The compare uses !== semantics in simulation; in synthesis it reduces to a plain compare.

Decomposition:
- Package circuit_2_pkg holds:
  - FSM state enum: IDLE, SETTLE, SAMPLE.
  - Truth-table constant CIRCUIT_2_EXPECTED = 8'hE2.
  - Worst-case path delay constant = 20.
  - Vector width constant = 3.
- One sub-module, circuit_2_settle_timer: loadable up-counter with clear and a terminal-count flag at SETTLE_CYCLES-1. Instantiated once.

Test Plan:
1. Reset, then start pulse, with circuit_2 connected at gate delays and period 1 unit -> busy high for 200 cycles; done=1, pass=1, err_count=0, fail_mask=8'h00.
2. o_in tied to 0 -> done=1, pass=0, err_count=4, fail_mask=8'hE2.
3. SETTLE_CYCLES=5 with the real circuit_2 (settle shorter than the 20-unit path) -> some bits set in fail_mask. Check err_count equals popcount(fail_mask).
4. Repeated start pulses while busy, including one every cycle -> sweep length stays 8*(S+1); vec sequence a,b,c = 000..111 each held S+1 cycles.
5. rst asserted at vector 3 mid-SETTLE -> next cycle all outputs 0, state IDLE. A new start completes a clean sweep with pass=1.
6. After a pass, start again with o_in forced to 1 -> done cleared on the accept edge; final err_count=4, fail_mask=8'h1D.

Source files
------------

// File: rtl/circuit_2_pkg.sv
// rtl/circuit_2_pkg.sv - shared types and constants for the circuit_2 sweep checker
package circuit_2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE
    } state_e;

    // Truth table of circuit_2, bit index = {a,b,c}
    localparam logic [7:0] CIRCUIT_2_EXPECTED   = 8'hE2;
    localparam int         CIRCUIT_2_WORST_PATH = 20;
    localparam int         VEC_W                = 3;
    localparam int         NUM_VECS             = 1 << VEC_W;

endpackage

// File: rtl/circuit_2_sweep_checker_if.sv
// rtl/circuit_2_sweep_checker_if.sv - vector/result bundle between checker and block under check
interface circuit_2_sweep_checker_if;

    logic       start;
    logic       o_in;
    logic       a;
    logic       b;
    logic       c;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_count;
    logic [7:0] fail_mask;

    modport master (
        input  start, o_in,
        output a, b, c, busy, done, pass, err_count, fail_mask
    );

    modport slave (
        output start, o_in,
        input  a, b, c, busy, done, pass, err_count, fail_mask
    );

endinterface

// File: rtl/circuit_2_settle_timer.sv
// rtl/circuit_2_settle_timer.sv - clearable up-counter flagging the last settle cycle
module circuit_2_settle_timer #(
    parameter int SETTLE_CYCLES = 24,
    parameter int CNT_W         = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == CNT_W'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/circuit_2_sweep_checker.sv
// rtl/circuit_2_sweep_checker.sv - sweeps {a,b,c} over 0..7, samples o after a settle window
module circuit_2_sweep_checker
    import circuit_2_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 24,
    parameter logic [7:0] EXPECTED      = CIRCUIT_2_EXPECTED,
    parameter int         CNT_W         = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    circuit_2_sweep_checker_if.master   bus
);

    state_e           state_q, state_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [3:0]       err_count_q, err_count_d;
    logic [7:0]       fail_mask_q, fail_mask_d;

    logic timer_clr;
    logic timer_en;
    logic settle_tc;
    logic mismatch;

    circuit_2_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_settle_timer (
        .clk (clk),
        .rst (rst),
        .clr (timer_clr),
        .en  (timer_en),
        .tc  (settle_tc)
    );

    // Case-inequality so an undriven or unknown o counts as a failure
    assign mismatch = (bus.o_in !== EXPECTED[vec_q]);

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        err_count_d = err_count_q;
        fail_mask_d = fail_mask_q;
        timer_clr   = 1'b0;
        timer_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d     = SETTLE;
                    vec_d       = '0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    err_count_d = '0;
                    fail_mask_d = '0;
                    timer_clr   = 1'b1;
                end
            end
            SETTLE: begin
                timer_en = 1'b1;
                if (settle_tc) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                timer_clr = 1'b1;
                if (mismatch) begin
                    fail_mask_d[vec_q] = 1'b1;
                    err_count_d        = err_count_q + 4'd1;
                end
                if (vec_q == VEC_W'(NUM_VECS - 1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_count_q == 4'd0) && !mismatch;
                end else begin
                    state_d = SETTLE;
                    vec_d   = vec_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= '0;
            fail_mask_q <= '0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_count_q <= err_count_d;
            fail_mask_q <= fail_mask_d;
        end
    end

    assign bus.a         = vec_q[2];
    assign bus.b         = vec_q[1];
    assign bus.c         = vec_q[0];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_count_q;
    assign bus.fail_mask = fail_mask_q;

endmodule
